// File: rtl/ercmn_pipe.sv
// Approximate OR/AND-tree multiplier with masked error recovery, 3-stage valid/ready pipeline.
// Optional collision statistics counter enabled by defining ERCMN_PIPE_STAT_EN.
module ercmn_pipe #(
  parameter int WIDTH = 8,
  parameter int ID_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     dat_in_a,
  input  logic [WIDTH-1:0]     dat_in_b,
  input  logic [2*WIDTH-1:0]   mask,
  input  logic [ID_W-1:0]      in_id,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   dat_o,
  output logic [ID_W-1:0]      out_id
`ifdef ERCMN_PIPE_STAT_EN
  ,
  input  logic                 stat_clr,
  output logic [15:0]          stat_cnt
`endif
);

  localparam int PW   = 2 * WIDTH;
  localparam int LVLS = $clog2(WIDTH);

  // Carries are never propagated; each level keeps S=X|Y and collects C=X&Y at its own weight.
  function automatic void reduce_rows(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [PW-1:0]    s,
    output logic [PW-1:0]    e
`ifdef ERCMN_PIPE_STAT_EN
    ,
    output logic             coll
`endif
  );
    logic [PW-1:0] rows [WIDTH];
    logic [PW-1:0] c;
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i]) rows[i] = {{WIDTH{1'b0}}, b} << i;
      else      rows[i] = {PW{1'b0}};
    end
    e = {PW{1'b0}};
`ifdef ERCMN_PIPE_STAT_EN
    coll = 1'b0;
`endif
    for (int l = 0; l < LVLS; l++) begin
      for (int j = 0; j < (WIDTH >> (l + 1)); j++) begin
        c = rows[2*j] & rows[2*j+1];
`ifdef ERCMN_PIPE_STAT_EN
        coll = coll | (|(e & c));
`endif
        e       = e | c;
        rows[j] = rows[2*j] | rows[2*j+1];
      end
    end
    s = rows[0];
  endfunction

  logic              v1_r, v2_r;
  logic [WIDTH-1:0]  a1_r, b1_r;
  logic [PW-1:0]     m1_r;
  logic [ID_W-1:0]   id1_r, id2_r;
  logic [PW-1:0]     sf2_r, em2_r;
  logic [PW-1:0]     sf_s, e_s;
  logic              adv_s;
`ifdef ERCMN_PIPE_STAT_EN
  logic              coll_s, coll2_r, coll3_r;
`endif

  assign in_ready = !(out_valid && !out_ready);
  assign adv_s    = in_ready;

  // Stage-2 combinational tree reduction of the registered operands.
  always_comb begin
    sf_s = {PW{1'b0}};
    e_s  = {PW{1'b0}};
`ifdef ERCMN_PIPE_STAT_EN
    coll_s = 1'b0;
    reduce_rows(a1_r, b1_r, sf_s, e_s, coll_s);
`else
    reduce_rows(a1_r, b1_r, sf_s, e_s);
`endif
  end

  // Whole pipeline moves together; a stalled output freezes every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r      <= 1'b0;
      v2_r      <= 1'b0;
      out_valid <= 1'b0;
      a1_r      <= {WIDTH{1'b0}};
      b1_r      <= {WIDTH{1'b0}};
      m1_r      <= {PW{1'b0}};
      id1_r     <= {ID_W{1'b0}};
      sf2_r     <= {PW{1'b0}};
      em2_r     <= {PW{1'b0}};
      id2_r     <= {ID_W{1'b0}};
      dat_o     <= {PW{1'b0}};
      out_id    <= {ID_W{1'b0}};
`ifdef ERCMN_PIPE_STAT_EN
      coll2_r   <= 1'b0;
      coll3_r   <= 1'b0;
`endif
    end else if (adv_s) begin
      v1_r      <= in_valid;
      v2_r      <= v1_r;
      out_valid <= v2_r;
      if (in_valid) begin
        a1_r  <= dat_in_a;
        b1_r  <= dat_in_b;
        m1_r  <= mask;
        id1_r <= in_id;
      end
      if (v1_r) begin
        sf2_r <= sf_s;
        em2_r <= e_s & m1_r;
        id2_r <= id1_r;
`ifdef ERCMN_PIPE_STAT_EN
        coll2_r <= coll_s;
`endif
      end
      if (v2_r) begin
        dat_o  <= sf2_r + em2_r;
        out_id <= id2_r;
`ifdef ERCMN_PIPE_STAT_EN
        coll3_r <= coll2_r;
`endif
      end
    end
  end

`ifdef ERCMN_PIPE_STAT_EN
  // Saturating count of retired transactions with a multi-carry weight; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt <= 16'h0000;
    end else if (stat_clr) begin
      stat_cnt <= 16'h0000;
    end else if (out_valid && out_ready && coll3_r && (stat_cnt != 16'hFFFF)) begin
      stat_cnt <= stat_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_ercmn_pipe.sv
// Self-checking bench for ercmn_pipe (WIDTH=8): directed table, stall, random stream, mid-flight reset.
module tb_ercmn_pipe;

  localparam int W    = 8;
  localparam int ID_W = 4;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    dat_in_a;
  logic [W-1:0]    dat_in_b;
  logic [2*W-1:0]  mask;
  logic [ID_W-1:0] in_id;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  dat_o;
  logic [ID_W-1:0] out_id;
`ifdef ERCMN_PIPE_STAT_EN
  logic            stat_clr;
  logic [15:0]     stat_cnt;
  logic [15:0]     stat_exp;
`endif

  int checks   = 0;
  int failures = 0;

  ercmn_pipe #(.WIDTH(W), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dat_in_a  (dat_in_a),
    .dat_in_b  (dat_in_b),
    .mask      (mask),
    .in_id     (in_id),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dat_o     (dat_o),
    .out_id    (out_id)
`ifdef ERCMN_PIPE_STAT_EN
    ,
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] m;
    logic [15:0] exp;
    logic        coll;
  } vec_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [15:0]     d;
  } exp_t;

  vec_t vt [10];
  exp_t q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Independent golden model: per-weight carry counts, returns {collision, result}.
  function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b, input logic [15:0] m);
    logic [15:0] lvl [8];
    logic [15:0] nx [8];
    int          cnt [16];
    int          n;
    logic [15:0] e;
    logic [15:0] c;
    logic        coll;
    for (int k = 0; k < 16; k++) cnt[k] = 0;
    for (int i = 0; i < 8; i++) lvl[i] = a[i] ? (16'(b) << i) : 16'h0000;
    n = 8;
    while (n > 1) begin
      for (int j = 0; j < n / 2; j++) begin
        nx[j] = lvl[2*j] | lvl[2*j+1];
        c     = lvl[2*j] & lvl[2*j+1];
        for (int k = 0; k < 16; k++) if (c[k]) cnt[k]++;
      end
      for (int j = 0; j < n / 2; j++) lvl[j] = nx[j];
      n = n / 2;
    end
    e    = 16'h0000;
    coll = 1'b0;
    for (int k = 0; k < 16; k++) begin
      e[k] = (cnt[k] > 0);
      if (cnt[k] > 1) coll = 1'b1;
    end
    return {coll, 16'(lvl[0] + (e & m))};
  endfunction

  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [15:0] m,
                       input logic [ID_W-1:0] id, input logic [15:0] exp,
                       input logic coll, input logic clr, input string nm);
    int lat;
    in_valid = 1'b1; dat_in_a = a; dat_in_b = b; mask = m; in_id = id;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dat_in_a = 8'($urandom); dat_in_b = 8'($urandom); mask = 16'($urandom); in_id = ID_W'($urandom);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'd3);
    chk({nm, " dat_o"}, 64'(dat_o), 64'(exp));
    chk({nm, " out_id"}, 64'(out_id), 64'(id));
`ifdef ERCMN_PIPE_STAT_EN
    stat_clr = clr;
    if (clr) stat_exp = 16'h0000;
    else if (coll && stat_exp != 16'hFFFF) stat_exp = stat_exp + 16'h0001;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    chk({nm, " stat_cnt"}, 64'(stat_cnt), 64'(stat_exp));
`endif
  endtask

  initial begin
    logic            acc;
    logic            hold;
    logic            stalled_prev;
    logic [15:0]     prev_d;
    logic [ID_W-1:0] prev_id;
    logic [16:0]     mr;
    logic            seen;
    exp_t            e;
    int              idx;
    int              got;
    int              nid;

    vt[0] = '{8'h03, 8'h05, 16'hFFFF, 16'h000F, 1'b0};
    vt[1] = '{8'hFF, 8'hFF, 16'hFFFF, 16'hBFFD, 1'b1};
    vt[2] = '{8'hFF, 8'hFF, 16'h0000, 16'h7FFF, 1'b1};
    vt[3] = '{8'h00, 8'hAB, 16'hFFFF, 16'h0000, 1'b0};
    vt[4] = '{8'h01, 8'hAB, 16'hFFFF, 16'h00AB, 1'b0};
    vt[5] = '{8'h80, 8'hFF, 16'h0000, 16'h7F80, 1'b0};
    vt[6] = '{8'h81, 8'h01, 16'hFFFF, 16'h0081, 1'b0};
    vt[7] = '{8'h03, 8'h03, 16'hFFFF, 16'h0009, 1'b0};
    vt[8] = '{8'h0F, 8'h0F, 16'hFFFF, 16'h00BD, 1'b1};
    vt[9] = '{8'h0F, 8'h0F, 16'h0002, 16'h0081, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    dat_in_a = 8'h00; dat_in_b = 8'h00; mask = 16'h0000; in_id = 4'h0;
`ifdef ERCMN_PIPE_STAT_EN
    stat_clr = 1'b0; stat_exp = 16'h0000;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset dat_o", 64'(dat_o), 64'd0);
    chk("reset out_id", 64'(out_id), 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset in_ready", 64'(in_ready), 64'd1);
    chk("post-reset out_valid", 64'(out_valid), 64'd0);
`ifdef ERCMN_PIPE_STAT_EN
    chk("reset stat_cnt", 64'(stat_cnt), 64'd0);
`endif

    for (int i = 0; i < 10; i++) begin
      apply(vt[i].a, vt[i].b, vt[i].m, ID_W'(i + 3), vt[i].exp, vt[i].coll, 1'b0, $sformatf("vec%0d", i));
    end
    apply(vt[1].a, vt[1].b, vt[1].m, 4'hA, vt[1].exp, vt[1].coll, 1'b1, "clr_with_inc");
    @(posedge clk); #1;

    // Back-to-back ids 0..3 with a three-cycle output stall.
    idx = 0; got = 0; stalled_prev = 1'b0; prev_d = 16'h0000; prev_id = 4'h0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 6);
      if (idx < 4) begin
        in_valid = 1'b1; dat_in_a = vt[idx].a; dat_in_b = vt[idx].b; mask = vt[idx].m; in_id = ID_W'(idx);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stalled_prev && out_valid) begin
        chk("stall dat_o frozen", 64'(dat_o), 64'(prev_d));
        chk("stall out_id frozen", 64'(out_id), 64'(prev_id));
      end
      if (out_valid && !out_ready) chk("stall in_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        chk("stall order id", 64'(out_id), 64'(got));
        chk("stall data", 64'(dat_o), 64'(vt[got % 4].exp));
        got++;
      end
      stalled_prev = out_valid && !out_ready;
      prev_d = dat_o; prev_id = out_id;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    chk("stall retired count", 64'(got), 64'd4);

    // Random stream with random backpressure against the golden model.
    hold = 1'b0; nid = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        dat_in_a = 8'($urandom); dat_in_b = 8'($urandom); mask = 16'($urandom); in_id = ID_W'(nid);
      end
      #1;
      if (out_valid && !out_ready) chk("rand stall in_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rand spurious output", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("rand result", 64'({out_id, dat_o}), 64'({e.id, e.d}));
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin
        mr = model(dat_in_a, dat_in_b, mask);
        q.push_back('{in_id, mr[15:0]});
        nid++;
      end
      hold = in_valid && !in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      #1;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("drain spurious output", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("drain result", 64'({out_id, dat_o}), 64'({e.id, e.d}));
        end
      end
      @(posedge clk); #1;
    end
    chk("rand queue empty", 64'(q.size()), 64'd0);

    // Reset with two transactions in flight, the older one stalled at the output.
    out_ready = 1'b0;
    in_valid = 1'b1; dat_in_a = vt[1].a; dat_in_b = vt[1].b; mask = vt[1].m; in_id = 4'h5;
    @(posedge clk); #1;
    dat_in_a = vt[0].a; dat_in_b = vt[0].b; mask = vt[0].m; in_id = 4'h6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre-reset out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid reset out_valid", 64'(out_valid), 64'd0);
    chk("mid reset dat_o", 64'(dat_o), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
`ifdef ERCMN_PIPE_STAT_EN
    stat_exp = 16'h0000;
`endif
    seen = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      dat_in_a = 8'($urandom); dat_in_b = 8'($urandom); mask = 16'($urandom);
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("no output after reset", 64'(seen), 64'd0);
    apply(vt[8].a, vt[8].b, vt[8].m, 4'h9, vt[8].exp, vt[8].coll, 1'b0, "after reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
